// File: rtl/bp_cfg_sequencer.sv
// Boot-time programmable configuration sequencer: streams a writable table of
// (address, data) entries to one or all destination tiles over valid/ready.
module bp_cfg_sequencer #(
    parameter int unsigned cfg_els_p    = 16,
    parameter int unsigned num_dst_p    = 4,
    parameter int unsigned addr_width_p = 20,
    parameter int unsigned data_width_p = 64,
    localparam int unsigned idx_width_lp = (cfg_els_p == 1) ? 1 : $clog2(cfg_els_p),
    localparam int unsigned dst_width_lp = (num_dst_p == 1) ? 1 : $clog2(num_dst_p),
    localparam int unsigned cnt_width_lp = $clog2(cfg_els_p * num_dst_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_v_i,
    input  logic [idx_width_lp-1:0] w_idx_i,
    input  logic                    w_en_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [data_width_p-1:0] w_data_i,
    input  logic                    start_i,
    input  logic                    bcast_i,
    input  logic [dst_width_lp-1:0] dst_i,
    output logic                    cfg_v_o,
    input  logic                    cfg_ready_i,
    output logic [dst_width_lp-1:0] cfg_dst_o,
    output logic [addr_width_p-1:0] cfg_addr_o,
    output logic [data_width_p-1:0] cfg_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [cnt_width_lp-1:0] count_o
);

    localparam logic [1:0] s_idle = 2'd0;
    localparam logic [1:0] s_send = 2'd1;
    localparam logic [1:0] s_done = 2'd2;

    localparam logic [dst_width_lp-1:0] last_dst_lp = dst_width_lp'(num_dst_p - 1);

    logic [1:0]              state_r;
    logic [cfg_els_p-1:0]    en_r;
    logic [addr_width_p-1:0] addr_mem [cfg_els_p];
    logic [data_width_p-1:0] data_mem [cfg_els_p];
    logic [idx_width_lp-1:0] idx_r;
    logic [dst_width_lp-1:0] dst_r;
    logic [dst_width_lp-1:0] last_dst_r;
    logic [cnt_width_lp-1:0] count_r;

    logic                    in_idle;
    logic                    in_send;
    logic                    write_ok;
    logic                    cur_v;
    logic                    handshake;
    logic                    advance;
    logic                    last_idx;
    logic [dst_width_lp-1:0] start_dst;

    always_comb begin
        in_idle   = (state_r == s_idle);
        in_send   = (state_r == s_send);
        write_ok  = in_idle && w_v_i && (32'(w_idx_i) < cfg_els_p);
        cur_v     = in_send && en_r[idx_r];
        handshake = cur_v && cfg_ready_i;
        // Disabled entries are skipped without waiting on the consumer.
        advance   = in_send && (!en_r[idx_r] || cfg_ready_i);
        last_idx  = (32'(idx_r) == cfg_els_p - 1);
        start_dst = (32'(dst_i) >= num_dst_p) ? last_dst_lp : dst_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= s_idle;
            en_r       <= '0;
            idx_r      <= '0;
            dst_r      <= '0;
            last_dst_r <= '0;
            count_r    <= '0;
        end else begin
            case (state_r)
                s_idle: begin
                    if (write_ok) en_r[w_idx_i] <= w_en_i;
                    if (start_i) begin
                        state_r    <= s_send;
                        idx_r      <= '0;
                        count_r    <= '0;
                        dst_r      <= bcast_i ? '0 : start_dst;
                        last_dst_r <= bcast_i ? last_dst_lp : start_dst;
                    end
                end
                s_send: begin
                    if (handshake) count_r <= count_r + cnt_width_lp'(1);
                    if (advance) begin
                        if (last_idx) begin
                            idx_r <= '0;
                            if (dst_r == last_dst_r) state_r <= s_done;
                            else                     dst_r   <= dst_r + dst_width_lp'(1);
                        end else begin
                            idx_r <= idx_r + idx_width_lp'(1);
                        end
                    end
                end
                s_done:  state_r <= s_idle;
                default: state_r <= s_idle;
            endcase
        end
    end

    // Payload storage needs no reset; only the valid bits are cleared.
    always_ff @(posedge clk_i) begin
        if (write_ok) begin
            addr_mem[w_idx_i] <= w_addr_i;
            data_mem[w_idx_i] <= w_data_i;
        end
    end

    always_comb begin
        cfg_v_o    = cur_v;
        cfg_dst_o  = in_send ? dst_r : '0;
        cfg_addr_o = in_send ? addr_mem[idx_r] : '0;
        cfg_data_o = in_send ? data_mem[idx_r] : '0;
        busy_o     = in_send;
        done_o     = (state_r == s_done);
        count_o    = count_r;
    end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Self-checking bench for bp_cfg_sequencer: vector table of sequences plus
// hand-written reset-abort and same-cycle write/start cases.
module tb_bp_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        w_v_i;
    logic [3:0]  w_idx_i;
    logic        w_en_i;
    logic [19:0] w_addr_i;
    logic [63:0] w_data_i;
    logic        start_i;
    logic        bcast_i;
    logic [1:0]  dst_i;
    logic        cfg_v_o;
    logic        cfg_ready_i;
    logic [1:0]  cfg_dst_o;
    logic [19:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic        busy_o;
    logic        done_o;
    logic [6:0]  count_o;

    always #5 clk = ~clk;

    bp_cfg_sequencer #(
        .cfg_els_p   (16),
        .num_dst_p   (4),
        .addr_width_p(20),
        .data_width_p(64)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .w_v_i      (w_v_i),
        .w_idx_i    (w_idx_i),
        .w_en_i     (w_en_i),
        .w_addr_i   (w_addr_i),
        .w_data_i   (w_data_i),
        .start_i    (start_i),
        .bcast_i    (bcast_i),
        .dst_i      (dst_i),
        .cfg_v_o    (cfg_v_o),
        .cfg_ready_i(cfg_ready_i),
        .cfg_dst_o  (cfg_dst_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_data_o (cfg_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .count_o    (count_o)
    );

    int checks = 0;
    int errors = 0;

    bit          sh_en   [16];
    logic [19:0] sh_addr [16];
    logic [63:0] sh_data [16];

    logic [19:0] q_addr[$];
    logic [63:0] q_data[$];
    logic [1:0]  q_dst[$];

    typedef struct {
        logic [15:0] mask;
        bit          wr_tbl;
        bit          bcast;
        logic [1:0]  dst;
        bit          bp;
        int          inj;
        bit          wr_start;
        bit          dstart;
        int          exp_count;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input int i, input bit en, input logic [19:0] a, input logic [63:0] d);
        w_v_i    = 1'b1;
        w_idx_i  = 4'(i);
        w_en_i   = en;
        w_addr_i = a;
        w_data_i = d;
        @(negedge clk);
        w_v_i    = 1'b0;
        sh_en[i]   = en;
        sh_addr[i] = a;
        sh_data[i] = d;
    endtask

    // Called at a negedge with the DUT idle; that cycle is the start cycle.
    task automatic run(input int tag, input bit bcast, input logic [1:0] dst, input bit bp,
                       input int inj, input bit wr_start, input bit dstart,
                       input int exp_count, input int exp_done);
        int  waitcnt;
        bit  rdy;
        start_i = 1'b1;
        bcast_i = bcast;
        dst_i   = dst;
        if (wr_start) begin
            w_v_i    = 1'b1;
            w_idx_i  = 4'd0;
            w_en_i   = 1'b1;
            w_addr_i = 20'h55;
            w_data_i = 64'h5555;
            sh_en[0]   = 1'b1;
            sh_addr[0] = 20'h55;
            sh_data[0] = 64'h5555;
        end
        q_addr.delete();
        q_data.delete();
        q_dst.delete();
        for (int d = 0; d < 4; d++) begin
            if (bcast || d == int'(dst)) begin
                for (int i = 0; i < 16; i++) begin
                    if (sh_en[i]) begin
                        q_addr.push_back(sh_addr[i]);
                        q_data.push_back(sh_data[i]);
                        q_dst.push_back(2'(d));
                    end
                end
            end
        end
        waitcnt = 0;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            start_i     = 1'b0;
            w_v_i       = 1'b0;
            cfg_ready_i = 1'b0;
            if (k == inj) begin
                w_v_i    = 1'b1;
                w_idx_i  = 4'd0;
                w_en_i   = 1'b1;
                w_addr_i = 20'h99;
                w_data_i = 64'h0;
                start_i  = 1'b1;
                bcast_i  = 1'b0;
                dst_i    = 2'd1;
            end
            chk($sformatf("v%0d busy k%0d", tag, k), 64'(busy_o), 64'(k < exp_done));
            chk($sformatf("v%0d done k%0d", tag, k), 64'(done_o), 64'(k == exp_done));
            if (k == 1) begin
                chk($sformatf("v%0d count_cleared", tag), 64'(count_o), 64'd0);
                if (wr_start) begin
                    chk($sformatf("v%0d first_v", tag), 64'(cfg_v_o), 64'd1);
                    chk($sformatf("v%0d first_addr", tag), 64'(cfg_addr_o), 64'h55);
                end
            end
            if (cfg_v_o) begin
                if (q_addr.size() == 0) begin
                    chk($sformatf("v%0d extra_beat k%0d", tag, k), 64'(cfg_v_o), 64'd0);
                end else begin
                    chk($sformatf("v%0d addr k%0d", tag, k), 64'(cfg_addr_o), 64'(q_addr[0]));
                    chk($sformatf("v%0d data k%0d", tag, k), cfg_data_o, q_data[0]);
                    chk($sformatf("v%0d dst k%0d", tag, k), 64'(cfg_dst_o), 64'(q_dst[0]));
                    rdy = bp ? (waitcnt == 2) : 1'b1;
                    if (rdy) begin
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                        void'(q_dst.pop_front());
                        waitcnt = 0;
                    end else begin
                        waitcnt++;
                    end
                    cfg_ready_i = rdy;
                end
            end
            if (k == exp_done && dstart) start_i = 1'b1;
        end
        start_i     = 1'b0;
        cfg_ready_i = 1'b0;
        chk($sformatf("v%0d beats_lost", tag), 64'(q_addr.size()), 64'd0);
        chk($sformatf("v%0d count", tag), 64'(count_o), 64'(exp_count));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h8009, 1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 12, 65};
        vecs[1] = '{16'h0006, 1'b1, 1'b0, 2'd2, 1'b0, 0, 1'b0, 1'b0, 2, 17};
        vecs[2] = '{16'h0021, 1'b1, 1'b0, 2'd1, 1'b1, 0, 1'b0, 1'b0, 2, 21};
        vecs[3] = '{16'h8009, 1'b1, 1'b1, 2'd0, 1'b1, 5, 1'b0, 1'b1, 12, 89};
        vecs[4] = '{16'h8009, 1'b0, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 12, 65};
        vecs[5] = '{16'hFFFF, 1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 64, 65};
        vecs[6] = '{16'h0000, 1'b1, 1'b0, 2'd3, 1'b0, 0, 1'b1, 1'b0, 1, 17};
        vecs[7] = '{16'h0000, 1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 0, 65};

        reset_i = 1'b1;
        w_v_i = 1'b0; w_idx_i = '0; w_en_i = 1'b0; w_addr_i = '0; w_data_i = '0;
        start_i = 1'b0; bcast_i = 1'b0; dst_i = '0; cfg_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sh_en[i] = 1'b0; sh_addr[i] = '0; sh_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst cfg_v", 64'(cfg_v_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst done", 64'(done_o), 64'd0);
        chk("rst count", 64'(count_o), 64'd0);
        chk("rst addr", 64'(cfg_addr_o), 64'd0);
        chk("rst data", cfg_data_o, 64'd0);
        chk("rst dst", 64'(cfg_dst_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Abort mid-SEND with a beat presented and the consumer stalled.
        do_write(0, 1'b1, 20'h10, 64'hA0);
        do_write(3, 1'b1, 20'h13, 64'hA3);
        start_i = 1'b1;
        bcast_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("abort pre_v", 64'(cfg_v_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("abort cfg_v", 64'(cfg_v_o), 64'd0);
        chk("abort busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("abort no_done", 64'(done_o), 64'd0);
        reset_i = 1'b0;
        for (int i = 0; i < 16; i++) sh_en[i] = 1'b0;
        @(negedge clk);
        run(100, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0, 0, 17);
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr_tbl) begin
                for (int i = 0; i < 16; i++) begin
                    do_write(i, vecs[v].mask[i], 20'h10 + 20'(i),
                             64'hDA7A_0000_0000_0000 | (64'(v) << 8) | 64'(i));
                end
            end
            run(v, vecs[v].bcast, vecs[v].dst, vecs[v].bp, vecs[v].inj,
                vecs[v].wr_start, vecs[v].dstart, vecs[v].exp_count, vecs[v].exp_done);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cfg_sequencer.md
# bp_cfg_sequencer

Runtime configuration sequencer. It holds a writable table of up to `cfg_els_p` configuration entries, each an (address, data) pair. On command it streams the valid entries to one destination tile or to all `num_dst_p` destinations over a valid/ready config interface. It sits between the host/loader and the per-tile config buses, replacing static per-config parameter tables with a boot-time programmable sequence.

## Interface
Parameters:
- `cfg_els_p`, 16, number of table entries (>=1).
- `num_dst_p`, 4, number of destination tiles (>=1).
- `addr_width_p`, 20, config register address width.
- `data_width_p`, 64, config data width.
- Derived: `idx_width_lp` = `BSG_SAFE_CLOG2(cfg_els_p)`; `dst_width_lp` = `BSG_SAFE_CLOG2(num_dst_p)`; `cnt_width_lp` = `BSG_SAFE_CLOG2(cfg_els_p*num_dst_p+1)`.

Ports:
- `clk_i` in 1: clock. The block uses one clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `w_v_i` in 1: table write strobe. Honoured only in IDLE.
- `w_idx_i` in `idx_width_lp`: entry index to write.
- `w_en_i` in 1: entry valid bit to store. 0 disables the entry.
- `w_addr_i` in `addr_width_p`: entry address.
- `w_data_i` in `data_width_p`: entry data.
- `start_i` in 1: start strobe. Honoured only in IDLE.
- `bcast_i` in 1: sampled with `start_i`. 1 sends to every destination; 0 sends to a single destination.
- `dst_i` in `dst_width_lp`: destination used when `bcast_i`=0.
- `cfg_v_o` out 1: config beat valid.
- `cfg_ready_i` in 1: consumer ready.
- `cfg_dst_o` out `dst_width_lp`: destination tile of the current beat.
- `cfg_addr_o` out `addr_width_p`: address of the current beat.
- `cfg_data_o` out `data_width_p`: data of the current beat.
- `busy_o` out 1: high while in SEND.
- `done_o` out 1: one-cycle pulse when a sequence completes.
- `count_o` out `cnt_width_lp`: number of handshakes in the current or last sequence.

## Operation
States:
- IDLE
  - `w_v_i` writes `{w_en_i, w_addr_i, w_data_i}` into entry `w_idx_i`.
  - `w_idx_i` >= `cfg_els_p` is ignored.
  - `start_i` captures the mode. In broadcast mode, `dst` starts at 0 and `last_dst` = `num_dst_p`-1. In single mode, `dst` = `dst_i` and `last_dst` = `dst_i`. `dst_i` >= `num_dst_p` is clamped to `num_dst_p`-1.
  - On start: `idx` <- 0, `count_o` <- 0, move to SEND.
- SEND
  - Each cycle examines entry `idx`.
  - If the entry is invalid: `cfg_v_o`=0 and advance in that cycle. A skipped entry costs one cycle.
  - If the entry is valid: `cfg_v_o`=1 with the entry's address/data and the current `dst`. Hold until `cfg_ready_i`=1; that cycle is the handshake. Then `count_o`++ and advance.
  - Advance: if `idx` < `cfg_els_p`-1, `idx`++. Otherwise `idx` <- 0; if `dst` == `last_dst`, go to DONE, else `dst`++.
- DONE
  - `done_o`=1 for exactly one cycle, then IDLE.
- While not in IDLE, `w_v_i` and `start_i` are ignored. The table cannot change mid-sequence.
- Ordering: the outer loop is destination and the inner loop is entry index, ascending.
- `count_o` holds its final value until the next start. It never wraps: its maximum value is `cfg_els_p*num_dst_p`.

## Timing
- Reset (asynchronous, active-high) puts the block in IDLE:
  - All entry valid bits clear; the table address/data contents are don't-care.
  - `idx`=0, `dst`=0, `count_o`=0.
  - `cfg_v_o`=0, `busy_o`=0, `done_o`=0. `cfg_dst_o`, `cfg_addr_o` and `cfg_data_o` read 0 in IDLE.
- Reset asserted mid-sequence aborts immediately: `cfg_v_o` drops asynchronously and there is no `done_o` pulse.
- `cfg_*` outputs are driven from registers and table state only. They have no combinational path from `cfg_ready_i`.
- Valid/ready protocol: once `cfg_v_o`=1, the beat's addr/data/dst stay stable until the handshake.
- Start latency: `start_i` at cycle t gives `busy_o`=1 at t+1. Entry 0 is examined at t+1, so a valid entry 0 presents `cfg_v_o` at t+1.
- Throughput: one beat per cycle when `cfg_ready_i` is held at 1.
- Sequence length: with E valid entries, D destinations and zero backpressure, SEND lasts `cfg_els_p`*D cycles. `done_o` rises the following cycle, and `busy_o`=0 in the DONE cycle.
- Write-to-read: a write in IDLE at cycle t is visible to a start at t. Write and start in the same cycle: the write lands, and the sequence sees it.
- Zero valid entries: no `cfg_v_o`. The walk still runs full length, then `done_o` pulses and `count_o` reads 0.
- `start_i` during DONE is ignored. It is accepted in IDLE only, from the cycle after DONE.

## Test plan
- Reset: assert `reset_i` mid-SEND with `cfg_v_o`=1 -> `cfg_v_o`=0 and `busy_o`=0 immediately. After release, a start with no writes yields 16 idle SEND cycles, then `done_o`, with `count_o`=0.
- Broadcast: entries 0, 3 and 15 valid (addr 0x10/0x13/0x1F), `num_dst_p`=4, ready held at 1 -> 12 beats in order dst0:{0x10,0x13,0x1F}, dst1:…, dst3:… `done_o` at start+65 and `count_o`=12.
- Single destination: `bcast_i`=0, `dst_i`=2, entries 1 and 2 valid -> 2 beats, both with `cfg_dst_o`=2. `done_o` at start+17.
- Backpressure: `cfg_ready_i` toggles 0,0,1 repeatedly -> each beat holds stable addr/data/dst for 3 cycles. No beat is lost or duplicated; `count_o` matches the number of valid entries.
- Ignored inputs while busy: `w_v_i` to entry 0 and `start_i` mid-sequence -> the stream is unchanged. A start after `done_o` shows the table unmodified.
- Same-cycle write+start: write entry 0 (addr 0x55) together with `start_i` -> the first beat at t+1 carries addr 0x55.
